// File: rtl/fft_frame_arbiter_if.sv
// Stream bus shared by the two source FIFOs, the frame arbiter and the FFT sink.
interface fft_frame_arbiter_if #(parameter int DATA_W = 32);
  logic [1:0]        src_avail;
  logic [1:0]        src_ready;
  logic [1:0]        src_valid;
  logic [DATA_W-1:0] src_data0;
  logic [DATA_W-1:0] src_data1;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sop;
  logic              out_eop;
  logic              out_channel;

  modport master (
    input  src_avail, src_valid, src_data0, src_data1, out_ready,
    output src_ready, out_data, out_valid, out_sop, out_eop, out_channel
  );

  modport slave (
    output src_avail, src_valid, src_data0, src_data1, out_ready,
    input  src_ready, out_data, out_valid, out_sop, out_eop, out_channel
  );
endinterface

// File: rtl/fft_frame_arbiter.sv
// Round-robin frame arbiter: grants the FFT sink to one FIFO for a whole
// frame, tags sop/eop/channel, and hides the FIFO read latency in a
// 3-entry skid buffer so the FFT side sees ready-latency 0.
module fft_frame_arbiter #(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 1024,
  parameter int CNT_W     = 11
)(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  fft_frame_arbiter_if.master bus,
  output logic                frame_done,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } beat_t;

  localparam int              LAST    = FRAME_LEN - 1;
  localparam logic [CNT_W:0]  FRAME_W = FRAME_LEN[CNT_W:0];
  localparam logic [CNT_W-1:0] FRAME_C = FRAME_LEN[CNT_W-1:0];
  localparam logic [CNT_W-1:0] LAST_C  = LAST[CNT_W-1:0];

  state_t           state, state_nxt;
  logic             grant, grant_nxt, last_grant;
  logic             inflight, eop_seen;
  logic [CNT_W-1:0] acc_cnt;
  logic [1:0]       occ, wr_ptr, rd_ptr;
  beat_t            skid [3];
  beat_t            head, in_beat;
  logic             rd_req, accept, pop, start, drain_done;

  function automatic logic [1:0] nxt_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Read-request, accept and pop decisions for the current cycle.
  always_comb begin
    rd_req = (state == STREAM)
           && (({1'b0, acc_cnt} + (CNT_W+1)'(inflight)) < FRAME_W)
           && (({1'b0, occ} + {2'b0, inflight}) < 3'd3);
    accept       = (state == STREAM) && inflight && bus.src_valid[grant];
    in_beat.data = grant ? bus.src_data1 : bus.src_data0;
    in_beat.sop  = (acc_cnt == '0);
    in_beat.eop  = (acc_cnt == LAST_C);
    head         = skid[rd_ptr];
    pop          = (occ != 2'd0) && bus.out_ready;
    start        = (state == IDLE) && enable && (bus.src_avail != 2'b00);
    grant_nxt    = (bus.src_avail == 2'b11) ? ~last_grant : bus.src_avail[1];
    drain_done   = (state == DRAIN) && (occ == 2'd0) && eop_seen;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (acc_cnt == FRAME_C) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant bookkeeping and frame counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      acc_cnt    <= '0;
      inflight   <= 1'b0;
      eop_seen   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      inflight   <= rd_req;
      frame_done <= drain_done;
      if (start) begin
        grant    <= grant_nxt;
        acc_cnt  <= '0;
        eop_seen <= 1'b0;
      end else begin
        if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
        if (pop && head.eop) eop_seen <= 1'b1;
      end
      if (drain_done) last_grant <= grant;
    end
  end

  // Skid buffer: circular 3-entry store with explicit occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) skid[i] <= '0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 2'd0;
    end else begin
      if (accept) begin
        skid[wr_ptr] <= in_beat;
        wr_ptr       <= nxt_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= nxt_ptr(rd_ptr);
      case ({accept, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign bus.src_ready   = grant ? {rd_req, 1'b0} : {1'b0, rd_req};
  assign bus.out_valid   = (occ != 2'd0);
  assign bus.out_data    = head.data;
  assign bus.out_sop     = head.sop & bus.out_valid;
  assign bus.out_eop     = head.eop & bus.out_valid;
  assign bus.out_channel = grant;
  assign busy            = (state != IDLE);
endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Directed bench for fft_frame_arbiter with FRAME_LEN=8 and two FIFO models
// that return a word one cycle after each read request.
module tb_fft_frame_arbiter;
  localparam int DATA_W = 32, FRAME_LEN = 8, CNT_W = 4;

  logic clock = 1'b0, reset_n = 1'b0, enable = 1'b0;
  logic frame_done, busy;
  int   errors = 0, checks = 0;

  fft_frame_arbiter_if #(.DATA_W(DATA_W)) bus();

  fft_frame_arbiter #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .bus(bus), .frame_done(frame_done), .busy(busy)
  );

  always #5 clock = ~clock;

  // FIFO models: request latched away from the edge, word delivered next edge.
  logic [DATA_W-1:0] mem0 [128];
  logic [DATA_W-1:0] mem1 [128];
  int   wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
  logic [1:0] req_l = 2'b00;
  assign bus.src_avail = {wr1 != rd1, wr0 != rd0};
  always @(negedge clock) req_l <= bus.src_ready;
  always @(posedge clock) begin
    bus.src_valid <= {req_l[1] && (wr1 != rd1), req_l[0] && (wr0 != rd0)};
    if (req_l[0] && (wr0 != rd0)) begin bus.src_data0 <= mem0[rd0]; rd0 <= rd0 + 1; end
    if (req_l[1] && (wr1 != rd1)) begin bus.src_data1 <= mem1[rd1]; rd1 <= rd1 + 1; end
  end

  // Output monitor.
  typedef struct {
    logic [DATA_W-1:0] data;
    logic sop, eop, ch;
    int   cyc;
  } beat_t;
  beat_t got [$];
  int   done_cnt = 0, cyc = 0, stall_err = 0, first_rdy = -1, first_vld = -1;
  bit   sr1_seen = 0, hot_err = 0;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  always @(negedge clock) begin
    cyc++;
    if (bus.out_valid && bus.out_ready)
      got.push_back('{bus.out_data, bus.out_sop, bus.out_eop, bus.out_channel, cyc});
    if (frame_done) done_cnt++;
    if (bus.src_ready[1]) sr1_seen = 1;
    if (bus.src_ready == 2'b11) hot_err = 1;
    if (bus.src_ready[0] && first_rdy < 0) first_rdy = cyc;
    if (bus.out_valid && first_vld < 0) first_vld = cyc;
    if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stall_err++;
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
  end

  task automatic load0(input logic [DATA_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) mem0[wr0 + i] = base + DATA_W'(i);
    wr0 = wr0 + n;
  endtask

  task automatic load1(input logic [DATA_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) mem1[wr1 + i] = base + DATA_W'(i);
    wr1 = wr1 + n;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_frames(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 300) begin @(negedge clock); n++; end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL %s timeout: frames=%0d required=%0d", name, done_cnt, target);
    end
  endtask

  // Compare one received beat against the bench's expectation.
  task automatic check_beat(input string name, input int idx, input logic [DATA_W-1:0] d,
                            input logic s, input logic e, input logic c);
    checks++;
    if (idx >= got.size()) begin
      errors++;
      $display("FAIL %s[%0d]: beat missing, required data=%h", name, idx, d);
    end else if (got[idx].data !== d || got[idx].sop !== s || got[idx].eop !== e || got[idx].ch !== c) begin
      errors++;
      $display("FAIL %s[%0d]: got data=%h sop=%b eop=%b ch=%b required data=%h sop=%b eop=%b ch=%b",
               name, idx, got[idx].data, got[idx].sop, got[idx].eop, got[idx].ch, d, s, e, c);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", bus.out_valid); end
    checks++; if (bus.src_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b required 00", bus.src_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", frame_done); end
    checks++; if ({bus.out_sop, bus.out_eop, bus.out_channel} !== 3'b000) begin
      errors++; $display("FAIL reset_tags: got %b required 000", {bus.out_sop, bus.out_eop, bus.out_channel}); end
    apply_reset();
  endtask

  task automatic test_single();
    got.delete(); sr1_seen = 0; first_rdy = -1; first_vld = -1;
    bus.out_ready = 1'b1;
    load0(32'h10, 8);
    enable = 1'b1;
    wait_frames(1, "single_frame");
    repeat (5) @(negedge clock);
    for (int i = 0; i < 8; i++) check_beat("single", i, 32'h10 + DATA_W'(i), i == 0, i == 7, 1'b0);
    checks++; if (got.size() != 8) begin errors++; $display("FAIL single_count: got %0d required 8", got.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_pulses: got %0d required 1", done_cnt); end
    checks++; if (sr1_seen) begin errors++; $display("FAIL single_ready1: got 1 required 0"); end
    checks++; if (first_vld - first_rdy != 2) begin
      errors++; $display("FAIL single_latency: got %0d required 2", first_vld - first_rdy); end
    checks++; if (got.size() == 8 && got[7].cyc - got[0].cyc != 7) begin
      errors++; $display("FAIL single_throughput: span %0d required 7", got[7].cyc - got[0].cyc); end
  endtask

  task automatic test_alternate();
    int base;
    enable = 1'b0;
    @(posedge clock); #1;
    load0(32'h100, 16);
    load1(32'h200, 16);
    apply_reset();
    got.delete(); base = done_cnt;
    enable = 1'b1;
    wait_frames(base + 4, "alternate_frames");
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 8; i++)
        check_beat("alternate", f * 8 + i,
                   ((f % 2) ? 32'h200 : 32'h100) + DATA_W'((f / 2) * 8 + i),
                   i == 0, i == 7, f[0]);
  endtask

  task automatic test_backpressure();
    logic [63:0] pat = 64'hA5C3_3C5A_96E1_1E69;
    int base;
    got.delete(); stall_err = 0; base = done_cnt;
    load0(32'h30, 8);
    for (int i = 0; i < 300 && done_cnt <= base; i++) begin
      @(posedge clock); #1 bus.out_ready = pat[i % 64];
    end
    bus.out_ready = 1'b1;
    wait_frames(base + 1, "backpressure_frame");
    for (int i = 0; i < 8; i++) check_beat("backpressure", i, 32'h30 + DATA_W'(i), i == 0, i == 7, 1'b0);
    checks++; if (got.size() != 8) begin errors++; $display("FAIL bp_count: got %0d required 8", got.size()); end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stall_hold: got %0d changes required 0", stall_err); end
  endtask

  task automatic test_stall();
    int base, n;
    got.delete(); sr1_seen = 0; base = done_cnt;
    load0(32'h40, 3);
    n = 0;
    while (!busy && n < 20) begin @(negedge clock); n++; end
    load1(32'h50, 8);
    repeat (20) @(negedge clock);
    checks++; if (got.size() != 3) begin errors++; $display("FAIL stall_partial: got %0d required 3", got.size()); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_valid: got %b required 0", bus.out_valid); end
    checks++; if (busy !== 1'b1 || bus.out_channel !== 1'b0) begin
      errors++; $display("FAIL stall_grant: busy=%b ch=%b required busy=1 ch=0", busy, bus.out_channel); end
    checks++; if (sr1_seen) begin errors++; $display("FAIL stall_ready1: got 1 required 0"); end
    load0(32'h43, 5);
    wait_frames(base + 2, "stall_frames");
    for (int i = 0; i < 8; i++) check_beat("stall_ch0", i, 32'h40 + DATA_W'(i), i == 0, i == 7, 1'b0);
    for (int i = 0; i < 8; i++) check_beat("stall_ch1", 8 + i, 32'h50 + DATA_W'(i), i == 0, i == 7, 1'b1);
  endtask

  task automatic test_enable_drop();
    int base, n;
    got.delete(); base = done_cnt;
    load0(32'h60, 16);
    n = 0;
    while (got.size() < 4 && n < 100) begin @(negedge clock); n++; end
    enable = 1'b0;
    wait_frames(base + 1, "enable_frame");
    repeat (20) @(negedge clock);
    checks++; if (got.size() != 8) begin errors++; $display("FAIL enable_count: got %0d required 8", got.size()); end
    checks++; if (busy !== 1'b0 || bus.src_ready !== 2'b00) begin
      errors++; $display("FAIL enable_hold: busy=%b ready=%b required 0/00", busy, bus.src_ready); end
    checks++; if (done_cnt != base + 1) begin errors++; $display("FAIL enable_done: got %0d required %0d", done_cnt, base + 1); end
    enable = 1'b1;
    wait_frames(base + 2, "enable_resume");
    for (int i = 0; i < 16; i++) check_beat("enable", i, 32'h60 + DATA_W'(i), (i % 8) == 0, (i % 8) == 7, 1'b0);
  endtask

  task automatic test_reset_mid();
    int base, n, nxt;
    got.delete();
    load0(32'h70, 8);
    n = 0;
    while (got.size() < 5 && n < 100) begin @(negedge clock); n++; end
    @(posedge clock); #1 reset_n = 1'b0; enable = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.src_ready !== 2'b00) begin
      errors++; $display("FAIL midreset_outputs: valid=%b busy=%b ready=%b required 0/0/00",
                         bus.out_valid, busy, bus.src_ready); end
    checks++; if ({bus.out_sop, bus.out_eop, bus.out_channel, frame_done} !== 4'b0000) begin
      errors++; $display("FAIL midreset_tags: got %b required 0000",
                         {bus.out_sop, bus.out_eop, bus.out_channel, frame_done}); end
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    nxt = rd0;
    load0(32'h80, 8);
    got.delete(); base = done_cnt;
    enable = 1'b1;
    wait_frames(base + 1, "midreset_frame");
    for (int i = 0; i < 8; i++) check_beat("midreset", i, mem0[nxt + i], i == 0, i == 7, 1'b0);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_stall();
    test_enable_drop();
    test_reset_mid();
    checks++; if (hot_err) begin errors++; $display("FAIL ready_onehot: both src_ready bits seen high"); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_frame_arbiter.md
Name: fft_frame_arbiter

Overview:
- Sits between two Avalon-MM-to-Avalon-ST write FIFOs (channel 0, channel 1) and the single FFT core's Avalon-ST sink.
- Grants the FFT input to one FIFO for exactly one frame of FRAME_LEN samples, then re-arbitrates round-robin.
- Generates sop/eop framing and a channel tag.
- Absorbs the FIFOs' 1-cycle ready-to-valid latency in a 3-entry skid buffer, so the FFT side has ready-latency 0.

Parameters:
- DATA_W, 32, sample width.
- FRAME_LEN, 1024, samples per FFT frame; must be ≥ 2.
- CNT_W, 11, counter width; must satisfy 2^CNT_W > FRAME_LEN.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits new frames to start; never aborts a frame already in progress.
- src_avail  in  2  per-FIFO not-empty flag (inverted scfifo empty).
- src_ready  out  2  per-FIFO read request, one-hot or zero.
- src_valid  in  2  per-FIFO beat valid; arrives 1 cycle after the matching src_ready while the FIFO is non-empty.
- src_data0  in  DATA_W  FIFO 0 data.
- src_data1  in  DATA_W  FIFO 1 data.
- out_data  out  DATA_W  sample to FFT.
- out_valid  out  1  output beat valid.
- out_ready  in  1  FFT sink ready, ready-latency 0.
- out_sop  out  1  first sample of frame; qualified by out_valid.
- out_eop  out  1  last sample of frame; qualified by out_valid.
- out_channel  out  1  source channel of the current frame.
- frame_done  out  1  one-cycle pulse when the last beat of a frame has left.
- busy  out  1  high in STREAM and DRAIN.

Behaviour:
- Reset values (asynchronous, active-low): all outputs 0, state IDLE, counters 0, skid buffer empty, last_grant = 1 so channel 0 wins first.
- State IDLE:
  - Waits for enable=1 and src_avail≠0.
  - Only one bit set: grant that channel.
  - Both bits set: grant ~last_grant.
  - Latch grant into out_channel; clear acc_cnt; go to STREAM on the next edge.
- State STREAM:
  - Definitions: inflight = src_ready[grant] registered from the previous cycle; occ = skid entries held (0..3).
  - src_ready[grant] = (acc_cnt + inflight < FRAME_LEN) & (occ + inflight < 3).
  - src_ready of the non-granted channel is always 0.
  - A beat is accepted when src_valid[grant] is 1. On acceptance, push {data, sop = (acc_cnt==0), eop = (acc_cnt==FRAME_LEN-1)} and increment acc_cnt.
  - src_valid seen on the non-granted channel, or without inflight: ignore it.
  - A ready issued while the FIFO is empty returns no beat; issue ready again later. The counter counts accepted beats only.
  - When acc_cnt reaches FRAME_LEN, go to DRAIN.
- State DRAIN:
  - Wait until occ==0 and the eop beat has been popped.
  - Then pulse frame_done for 1 cycle, set last_grant = grant, and return to IDLE.
  - Minimum idle gap between frames: 1 cycle.
- Output side:
  - out_valid = (occ≠0). out_data, out_sop and out_eop come from the head entry.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle leave occ unchanged; the buffer must never overflow.
- Throughput: with out_ready held at 1 and the granted FIFO non-empty, one sample per cycle after the first beat.
- Latency: first src_ready to first out_valid is 2 cycles (1 FIFO + 1 buffer write).
- out_ready low: occ saturates at 3 and src_ready deasserts; no beat is lost or duplicated.
- enable dropped mid-frame: the current frame completes; no new grant is made while enable=0.
- src_avail changing mid-frame: no effect on the current grant.
- Asserting reset_n low mid-frame: immediately returns to reset values.

Test Plan:
- FRAME_LEN=8; only FIFO 0 holds 8 words 0x10..0x17; out_ready=1 → 8 consecutive beats with out_channel=0, sop on 0x10, eop on 0x17, then one frame_done pulse; src_ready[1] stays 0.
- Both FIFOs hold 16 words each → frames alternate in the order ch0, ch1, ch0, ch1. Every frame carries exactly one sop and one eop, and the data order within each channel is preserved.
- out_ready toggled pseudo-randomly (50%) during a frame → occ never exceeds 3, all 8 words arrive in order, and no sample is duplicated or dropped.
- FIFO 0 runs empty after 3 words, and 5 more are written 20 cycles later → the frame stalls with out_valid=0 and completes with eop on the 8th word; FIFO 1 is not granted meanwhile.
- enable deasserted at beat 4 of a frame → the frame completes and frame_done pulses; no new grant follows until enable=1.
- reset_n pulsed low at beat 5 → outputs return to 0 immediately; after release, the next frame starts with channel 0 and sop on that channel's next FIFO word.
